// File: rtl/wb_b3_pkg.sv
// Shared Wishbone B3 constants and types for the line master and the RAM slave.
// Holds the cycle-type and burst-type encodings, the line master state enum
// and a small helper that picks one 32-bit word out of a 4-word line.
package wb_b3_pkg;

    localparam int LINE_WORDS = 4;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_CONST   = 3'b001;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_END     = 3'b111;

    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [1:0] BTE_WRAP4   = 2'b01;
    localparam logic [1:0] BTE_WRAP8   = 2'b10;
    localparam logic [1:0] BTE_WRAP16  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_RESP  = 2'd2
    } lineState_e;

    // Word idx of a 4x32-bit line, word 0 in the least significant bits.
    function automatic logic [31:0] lineWord(input logic [127:0] line, input logic [1:0] idx);
        return line[{idx, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/wb_b3_line_master_if.sv
// Wishbone B3 bus bundle between the line master and its slave.
// Signal names keep the master-side _o/_i suffixes so they read the same on
// both sides of the bus.
interface wb_b3_line_master_if #(
    parameter int aw = 32,
    parameter int dw = 32
);
    logic [aw-1:0] wb_adr_o;
    logic [dw-1:0] wb_dat_o;
    logic [3:0]    wb_sel_o;
    logic          wb_we_o;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic [2:0]    wb_cti_o;
    logic [1:0]    wb_bte_o;
    logic [dw-1:0] wb_dat_i;
    logic          wb_ack_i;
    logic          wb_err_i;
    logic          wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

endinterface

// File: rtl/wb_line_adr_gen.sv
// Beat address generator for a 4-beat line burst.
// Maps (start address, beat number, wrap mode) to the line word index and the
// byte address of that beat. In linear mode the critical word is ignored so
// the burst always walks words 0..3; in wrap mode it starts at the critical
// word and wraps modulo 4 inside the aligned line.
module wb_line_adr_gen
    import wb_b3_pkg::*;
#(
    parameter int aw = 32
) (
    input  logic [aw-1:0] start_i,
    input  logic [1:0]    beat_i,
    input  logic          wrapEn_i,
    output logic [1:0]    word_o,
    output logic [aw-1:0] adr_o
);

    logic [1:0] critWord;
    logic       unusedByteLane;

    // Word index is the (possibly forced-to-zero) critical word plus the beat, modulo 4.
    always_comb begin
        critWord = wrapEn_i ? start_i[3:2] : 2'b00;
        word_o   = critWord + beat_i;
        adr_o    = {start_i[aw-1:4], word_o, 2'b00};
    end

    assign unusedByteLane = ^start_i[1:0];

endmodule

// File: rtl/wb_b3_line_master.sv
// Wishbone B3 line master: one 4-word cache-line request becomes one
// registered-feedback incrementing burst, with the whole line buffered.
// Build option: define WB_LINE_WRAP_EN for critical-word-first 4-beat wrap
// bursts (bte = 01); without it bursts are linear from word 0 (bte = 00).
module wb_b3_line_master
    import wb_b3_pkg::*;
#(
    parameter int dw         = 32,
    parameter int aw         = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_we,
    input  logic [aw-1:0]            req_adr,
    input  logic [LINE_WORDS*dw-1:0] req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_err,
    output logic [LINE_WORDS*dw-1:0] rsp_rdata,
    wb_b3_line_master_if.master      wb
);

`ifdef WB_LINE_WRAP_EN
    localparam logic       WRAP_EN  = 1'b1;
    localparam logic [1:0] BTE_MODE = BTE_WRAP4;
`else
    localparam logic       WRAP_EN  = 1'b0;
    localparam logic [1:0] BTE_MODE = BTE_LINEAR;
`endif

    lineState_e state_q, state_d;

    logic [aw-1:0]            start_q, start_d;
    logic [1:0]               beat_q, beat_d;
    logic [LINE_WORDS*dw-1:0] line_q, line_d;
    logic                     errFlag_q, errFlag_d;
    logic                     rspValid_q, rspValid_d;
    logic                     cyc_q, cyc_d;
    logic                     stb_q, stb_d;
    logic                     we_q, we_d;
    logic [2:0]               cti_q, cti_d;
    logic [1:0]               bte_q, bte_d;
    logic [aw-1:0]            adr_q, adr_d;
    logic [dw-1:0]            dat_q, dat_d;

    logic                     busErr;
    logic [aw-1:0]            genStart;
    logic [1:0]               genBeat;
    logic [1:0]               genWord;
    logic [aw-1:0]            genAdr;

    assign busErr = wb.wb_err_i | wb.wb_rty_i;

    // In IDLE the generator looks at the incoming request (beat 0); in a burst
    // it looks one beat ahead so the next address is ready for the ack edge.
    assign genStart = (state_q == ST_IDLE) ? req_adr : start_q;
    assign genBeat  = (state_q == ST_IDLE) ? 2'd0 : beat_q + 2'd1;

    wb_line_adr_gen #(
        .aw(aw)
    ) u_adrGen (
        .start_i (genStart),
        .beat_i  (genBeat),
        .wrapEn_i(WRAP_EN),
        .word_o  (genWord),
        .adr_o   (genAdr)
    );

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: accept, finish on the last ack or any err/rty, release on rsp_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (req_valid) state_d = ST_BURST;
            ST_BURST: if (busErr || (wb.wb_ack_i && beat_q == 2'd3)) state_d = ST_RESP;
            ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: latch the line, step beats on ack, close the burst on end or error.
    always_comb begin
        start_d    = start_q;
        beat_d     = beat_q;
        line_d     = line_q;
        errFlag_d  = errFlag_q;
        rspValid_d = rspValid_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        we_d       = we_q;
        cti_d      = cti_q;
        bte_d      = bte_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    start_d   = req_adr;
                    beat_d    = 2'd0;
                    line_d    = req_wdata;
                    errFlag_d = 1'b0;
                    cyc_d     = 1'b1;
                    stb_d     = 1'b1;
                    we_d      = req_we;
                    cti_d     = CTI_INCR;
                    bte_d     = BTE_MODE;
                    adr_d     = genAdr;
                    dat_d     = lineWord(req_wdata, genWord);
                end
            end
            ST_BURST: begin
                if (busErr) begin
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    we_d       = 1'b0;
                    cti_d      = CTI_CLASSIC;
                    errFlag_d  = 1'b1;
                    rspValid_d = 1'b1;
                end else if (wb.wb_ack_i) begin
                    if (!we_q) begin
                        line_d[{adr_q[3:2], 5'd0} +: 32] = wb.wb_dat_i;
                    end
                    if (beat_q == 2'd3) begin
                        cyc_d      = 1'b0;
                        stb_d      = 1'b0;
                        we_d       = 1'b0;
                        cti_d      = CTI_CLASSIC;
                        rspValid_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 2'd1;
                        adr_d  = genAdr;
                        dat_d  = lineWord(line_q, genWord);
                        cti_d  = (beat_q == 2'd2) ? CTI_END : CTI_INCR;
                    end
                end
            end
            ST_RESP: begin
                if (rsp_ready) rspValid_d = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Datapath and bus output registers; reset clears everything.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            start_q    <= '0;
            beat_q     <= 2'd0;
            line_q     <= '0;
            errFlag_q  <= 1'b0;
            rspValid_q <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            bte_q      <= BTE_LINEAR;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            start_q    <= start_d;
            beat_q     <= beat_d;
            line_q     <= line_d;
            errFlag_q  <= errFlag_d;
            rspValid_q <= rspValid_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            we_q       <= we_d;
            cti_q      <= cti_d;
            bte_q      <= bte_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
        end
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign rsp_valid   = rspValid_q;
    assign rsp_err     = errFlag_q;
    assign rsp_rdata   = line_q;
    assign wb.wb_cyc_o = cyc_q;
    assign wb.wb_stb_o = stb_q;
    assign wb.wb_we_o  = we_q;
    assign wb.wb_cti_o = cti_q;
    assign wb.wb_bte_o = bte_q;
    assign wb.wb_adr_o = adr_q;
    assign wb.wb_dat_o = dat_q;
    assign wb.wb_sel_o = 4'hf;

endmodule

// File: tb/tb_wb_b3_line_master.sv
// Testbench for wb_b3_line_master with a registered-feedback RAM slave model.
// Expected addresses follow WB_LINE_WRAP_EN when the bench is built with it.
`timescale 1ns/1ps
module tb_wb_b3_line_master;
    import wb_b3_pkg::*;

`ifdef WB_LINE_WRAP_EN
    localparam logic [1:0]   EXP_BTE = 2'b01;
    localparam logic [127:0] ADR_1008 = {32'h1004, 32'h1000, 32'h100C, 32'h1008};
    localparam logic [127:0] ADR_1004 = {32'h1000, 32'h100C, 32'h1008, 32'h1004};
`else
    localparam logic [1:0]   EXP_BTE = 2'b00;
    localparam logic [127:0] ADR_1008 = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
    localparam logic [127:0] ADR_1004 = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
`endif
    localparam logic [127:0] ADR_1000 = {32'h100C, 32'h1008, 32'h1004, 32'h1000};
    localparam logic [127:0] ADR_2000 = {32'h200C, 32'h2008, 32'h2004, 32'h2000};
    localparam logic [127:0] ADR_3000 = {32'h300C, 32'h3008, 32'h3004, 32'h3000};
    localparam logic [127:0] LINE_A = {32'hA3A3_1003, 32'hA2A2_1002, 32'hA1A1_1001, 32'hA0A0_1000};
    localparam logic [127:0] LINE_D = {32'hD3D3_2003, 32'hD2D2_2002, 32'hD1D1_2001, 32'hD0D0_2000};
    localparam logic [127:0] LINE_F = {32'hF3F3_0003, 32'hF2F2_0002, 32'hF1F1_0001, 32'hF0F0_0000};
    localparam logic [31:0]  B0 = 32'hB0B0_3000;
    localparam logic [31:0]  B1 = 32'hB1B1_3001;
    localparam logic [31:0]  B2 = 32'hB2B2_3002;
    localparam logic [31:0]  B3 = 32'hB3B3_3003;

    logic         wb_clk_i = 1'b0;
    logic         wb_rst_i;
    logic         req_valid, req_ready, req_we;
    logic [31:0]  req_adr;
    logic [127:0] req_wdata;
    logic         rsp_valid, rsp_ready, rsp_err;
    logic [127:0] rsp_rdata;

    int checks = 0;
    int errors = 0;

    wb_b3_line_master_if #(.aw(32), .dw(32)) wb ();

    wb_b3_line_master #(.dw(32), .aw(32), .LINE_WORDS(4)) dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_we   (req_we),
        .req_adr  (req_adr),
        .req_wdata(req_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_err  (rsp_err),
        .rsp_rdata(rsp_rdata),
        .wb       (wb)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Slave model: RAM with configurable wait states and error injection on a chosen beat.
    logic [31:0] mem [0:4095];
    int   waitStates = 0;
    int   errBeat = 4;
    logic errIsRty = 1'b0;
    logic errWithAck = 1'b0;
    int   slvWait, slvBeat;

    function automatic logic [31:0] nextBeatAdr(input logic [31:0] a, input logic [1:0] bte);
        logic [31:0] n;
        if (bte == 2'b01) n = {a[31:4], a[3:2] + 2'd1, 2'b00};
        else n = a + 32'd4;
        return n;
    endfunction

    always @(posedge wb_clk_i) begin : slaveModel
        int b;
        logic [31:0] a;
        if (wb_rst_i || !(wb.wb_cyc_o && wb.wb_stb_o)) begin
            wb.wb_ack_i <= 1'b0;
            wb.wb_err_i <= 1'b0;
            wb.wb_rty_i <= 1'b0;
            wb.wb_dat_i <= 32'h0;
            slvWait <= 0;
            slvBeat <= 0;
            if (wb_rst_i) begin
                for (int i = 0; i < 4096; i++) mem[i] <= 32'h5A5A_0000 | 32'(i);
                for (int i = 0; i < 4; i++) mem[12'h400 + i] <= LINE_A[i*32 +: 32];
                mem[12'hC00] <= B0;
                mem[12'hC01] <= B1;
                mem[12'hC02] <= B2;
                mem[12'hC03] <= B3;
            end
        end else begin
            if (wb.wb_ack_i && wb.wb_we_o && !wb.wb_err_i) mem[wb.wb_adr_o[13:2]] <= wb.wb_dat_o;
            b = slvBeat + (wb.wb_ack_i ? 1 : 0);
            a = wb.wb_ack_i ? nextBeatAdr(wb.wb_adr_o, wb.wb_bte_o) : wb.wb_adr_o;
            wb.wb_ack_i <= 1'b0;
            wb.wb_err_i <= 1'b0;
            wb.wb_rty_i <= 1'b0;
            slvBeat <= b;
            if (!(wb.wb_err_i || wb.wb_rty_i || (wb.wb_ack_i && wb.wb_cti_o == 3'b111))) begin
                if (slvWait < waitStates) begin
                    slvWait <= slvWait + 1;
                end else begin
                    slvWait <= 0;
                    if (b == errBeat) begin
                        if (errIsRty) wb.wb_rty_i <= 1'b1;
                        else wb.wb_err_i <= 1'b1;
                        if (errWithAck) begin
                            wb.wb_ack_i <= 1'b1;
                            wb.wb_dat_i <= mem[a[13:2]];
                        end
                    end else begin
                        wb.wb_ack_i <= 1'b1;
                        wb.wb_dat_i <= mem[a[13:2]];
                    end
                end
            end
        end
    end

    // Beat monitor: records every cleanly acknowledged beat as seen on the bus.
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic [3:0]  sel;
        logic        we;
    } beat_t;
    beat_t beatLog[$];

    always @(negedge wb_clk_i) begin
        if (wb.wb_cyc_o && wb.wb_stb_o && wb.wb_ack_i && !wb.wb_err_i && !wb.wb_rty_i)
            beatLog.push_back('{wb.wb_adr_o, wb.wb_dat_o, wb.wb_cti_o, wb.wb_bte_o, wb.wb_sel_o, wb.wb_we_o});
    end

    typedef struct {
        string        name;
        logic         we;
        logic [31:0]  adr;
        logic [127:0] wdata;
        int           waits;
        int           errBeat;
        logic         errRty;
        logic         errAck;
        logic         chkData;
        logic [127:0] expData;
        logic         expErr;
        int           expLat;
        int           expBeats;
        logic [127:0] expAdr;
    } vec_t;
    vec_t vecs[8];

    function automatic vec_t mkVec(input string name, input logic we, input logic [31:0] adr,
                                   input logic [127:0] wdata, input int waits, input int eBeat,
                                   input logic eRty, input logic eAck, input logic chkData,
                                   input logic [127:0] expData, input logic expErr, input int expLat,
                                   input int expBeats, input logic [127:0] expAdr);
        vec_t v;
        v.name = name; v.we = we; v.adr = adr; v.wdata = wdata; v.waits = waits;
        v.errBeat = eBeat; v.errRty = eRty; v.errAck = eAck; v.chkData = chkData;
        v.expData = expData; v.expErr = expErr; v.expLat = expLat; v.expBeats = expBeats;
        v.expAdr = expAdr;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one line operation and checks latency, response and every acked beat.
    task automatic applyStimulus(input vec_t v);
        int lat;
        int idx;
        waitStates = v.waits;
        errBeat = v.errBeat;
        errIsRty = v.errRty;
        errWithAck = v.errAck;
        @(negedge wb_clk_i);
        lat = 0;
        while (!req_ready && lat < 50) begin
            @(negedge wb_clk_i);
            lat++;
        end
        beatLog.delete();
        req_valid = 1'b1;
        req_we = v.we;
        req_adr = v.adr;
        req_wdata = v.wdata;
        @(negedge wb_clk_i);
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 200) begin
            @(negedge wb_clk_i);
            lat++;
        end
        if (!rsp_valid) begin
            checkOutput({v.name, " rsp timeout"}, 0, 1);
            return;
        end
        checkOutput({v.name, " latency"}, lat, v.expLat);
        checkOutput({v.name, " rsp_err"}, rsp_err, v.expErr);
        if (v.chkData) checkOutput({v.name, " rsp_rdata"}, rsp_rdata, v.expData);
        checkOutput({v.name, " beat count"}, beatLog.size(), v.expBeats);
        for (int i = 0; i < beatLog.size() && i < v.expBeats; i++) begin
            checkOutput($sformatf("%s beat%0d adr", v.name, i), beatLog[i].adr, v.expAdr[i*32 +: 32]);
            checkOutput($sformatf("%s beat%0d cti", v.name, i), beatLog[i].cti, (i == 3) ? 3'b111 : 3'b010);
            checkOutput($sformatf("%s beat%0d bte", v.name, i), beatLog[i].bte, EXP_BTE);
            checkOutput($sformatf("%s beat%0d sel", v.name, i), beatLog[i].sel, 4'hf);
            checkOutput($sformatf("%s beat%0d we", v.name, i), beatLog[i].we, v.we);
            if (v.we) begin
                idx = int'(beatLog[i].adr[3:2]);
                checkOutput($sformatf("%s beat%0d dat", v.name, i), beatLog[i].dat, v.wdata[idx*32 +: 32]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = mkVec("linRead",   1'b0, 32'h1008, '0,     0, 4, 1'b0, 1'b0, 1'b1, LINE_A, 1'b0, 6,  4, ADR_1008);
        vecs[1] = mkVec("lineWrite", 1'b1, 32'h2000, LINE_D, 0, 4, 1'b0, 1'b0, 1'b0, '0,     1'b0, 6,  4, ADR_2000);
        vecs[2] = mkVec("readBack",  1'b0, 32'h2000, '0,     0, 4, 1'b0, 1'b0, 1'b1, LINE_D, 1'b0, 6,  4, ADR_2000);
        vecs[3] = mkVec("wait2Read", 1'b0, 32'h1000, '0,     2, 4, 1'b0, 1'b0, 1'b1, LINE_A, 1'b0, 14, 4, ADR_1000);
        vecs[4] = mkVec("errBeat2",  1'b0, 32'h3000, LINE_F, 0, 2, 1'b0, 1'b0, 1'b1,
                        {LINE_F[127:64], B1, B0}, 1'b1, 5, 2, ADR_3000);
        vecs[5] = mkVec("errAndAck", 1'b0, 32'h3000, LINE_F, 0, 1, 1'b0, 1'b1, 1'b1,
                        {LINE_F[127:32], B0}, 1'b1, 4, 1, ADR_3000);
        vecs[6] = mkVec("wait1Read", 1'b0, 32'h1004, '0,     1, 4, 1'b0, 1'b0, 1'b1, LINE_A, 1'b0, 10, 4, ADR_1004);
        vecs[7] = mkVec("rtyBeat0",  1'b0, 32'h3000, LINE_F, 0, 0, 1'b1, 1'b0, 1'b1, LINE_F, 1'b1, 3,  0, ADR_3000);

        wb_rst_i = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_adr = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;
        repeat (3) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        checkOutput("reset cyc", wb.wb_cyc_o, 1'b0);
        checkOutput("reset stb", wb.wb_stb_o, 1'b0);
        checkOutput("reset we", wb.wb_we_o, 1'b0);
        checkOutput("reset cti", wb.wb_cti_o, 3'b000);
        checkOutput("reset bte", wb.wb_bte_o, 2'b00);
        checkOutput("reset adr", wb.wb_adr_o, 32'h0);
        checkOutput("reset dat", wb.wb_dat_o, 32'h0);
        checkOutput("reset sel", wb.wb_sel_o, 4'hf);
        checkOutput("reset rsp_valid", rsp_valid, 1'b0);
        checkOutput("reset rsp_err", rsp_err, 1'b0);
        checkOutput("reset rsp_rdata", rsp_rdata, '0);
        checkOutput("reset req_ready", req_ready, 1'b1);
        wb_rst_i = 1'b0;

        for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

        // Response backpressure: held stable and no new request taken.
        waitStates = 0;
        errBeat = 4;
        errIsRty = 1'b0;
        errWithAck = 1'b0;
        @(negedge wb_clk_i);
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_we = 1'b0;
        req_adr = 32'h100C;
        req_wdata = '0;
        for (int i = 0; i < 50 && !rsp_valid; i++) @(negedge wb_clk_i);
        checkOutput("bp rsp_valid seen", rsp_valid, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge wb_clk_i);
            checkOutput($sformatf("bp hold%0d rsp_valid", i), rsp_valid, 1'b1);
            checkOutput($sformatf("bp hold%0d rsp_rdata", i), rsp_rdata, LINE_A);
            checkOutput($sformatf("bp hold%0d req_ready", i), req_ready, 1'b0);
            checkOutput($sformatf("bp hold%0d cyc", i), wb.wb_cyc_o, 1'b0);
        end
        rsp_ready = 1'b1;
        @(negedge wb_clk_i);
        req_valid = 1'b0;
        checkOutput("bp released rsp_valid", rsp_valid, 1'b0);
        checkOutput("bp released req_ready", req_ready, 1'b1);
        checkOutput("bp released cyc", wb.wb_cyc_o, 1'b0);

        // Reset in the middle of a wait-stated burst.
        waitStates = 2;
        @(negedge wb_clk_i);
        req_valid = 1'b1;
        req_adr = 32'h1000;
        @(negedge wb_clk_i);
        req_valid = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        checkOutput("midrst cyc before", wb.wb_cyc_o, 1'b1);
        checkOutput("midrst req_ready before", req_ready, 1'b0);
        wb_rst_i = 1'b1;
        @(negedge wb_clk_i);
        checkOutput("midrst cyc", wb.wb_cyc_o, 1'b0);
        checkOutput("midrst stb", wb.wb_stb_o, 1'b0);
        checkOutput("midrst adr", wb.wb_adr_o, 32'h0);
        checkOutput("midrst req_ready", req_ready, 1'b1);
        checkOutput("midrst rsp_valid", rsp_valid, 1'b0);
        wb_rst_i = 1'b0;
        applyStimulus(vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
